axi4_rd_responder: RTL and testbench
====================================

# axi4_rd_responder

AXI4 read-channel slave that closes the loop opposite the write-path decoder. It accepts AR requests, splits each burst into read requests of up to CHUNK_MAX_BEATS beats, and issues them to the TLP builder. It then takes the returned completion chunks and serializes them onto the AXI R channel with correct RID, RRESP and RLAST. One outstanding AXI burst and one outstanding chunk at a time.

## Interface
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 256, R beat width (32 B)
- CHUNK_MAX_BEATS, 4, max beats per read request / completion chunk (128 B)
- REQ_BDF, 16'h0100, requester BDF driven on req_bdf
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- arvalid_in  in  1  AR valid
- arready_out  out  1  AR ready
- arid_in  in  ID_WIDTH  AR ID
- araddr_in  in  ADDR_WIDTH  start address
- arlen_in  in  8  beats-1
- arsize_in  in  3  ignored; beats are always 32 B
- arburst_in  in  2  ignored; burst is always INCR
- rvalid_out  out  1  R valid
- rready_in  in  1  R ready
- rid_out  out  ID_WIDTH  latched ARID
- rdata_out  out  DATA_WIDTH  beat data
- rresp_out  out  2  2'b00 OKAY, 2'b10 SLVERR
- rlast_out  out  1  last beat of burst
- req_valid / req_ready  out / in  1 / 1  read-request handshake
- req_addr  out  ADDR_WIDTH  chunk start address
- req_length  out  8  chunk length in DW (beats×8)
- req_bdf  out  16  = REQ_BDF
- cpl_valid / cpl_ready  in / out  1 / 1  completion handshake
- cpl_data  in  DATA_WIDTH*CHUNK_MAX_BEATS  chunk data; beat k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- cpl_error  in  1  completion status not successful

## Operation
- FSM states: IDLE, REQ, WAIT_CPL, SEND. The reset state is IDLE.
- IDLE
  - arready_out=1.
  - On arvalid_in&&arready_out, latch id, cur_addr=araddr_in, beats_left=arlen_in+1 (9-bit, range 1..256), then go to REQ.
- REQ
  - req_valid=1, req_addr=cur_addr.
  - chunk_beats=min(beats_left,CHUNK_MAX_BEATS); req_length=chunk_beats*8.
  - On req_valid&&req_ready, go to WAIT_CPL.
- WAIT_CPL
  - cpl_ready=1.
  - On handshake, latch cpl_data into the chunk buffer and cpl_error into err_flag, clear beat_idx, then go to SEND.
- SEND
  - rvalid_out=1, rdata_out=buffer[beat_idx], rresp_out=err_flag?2'b10:2'b00, rid_out=latched id, rlast_out=(beats_left==1).
  - On rvalid_out&&rready_in: beat_idx++, beats_left--.
  - If that beat was the last of the chunk:
    - If beats_left becomes 0, go to IDLE.
    - Otherwise cur_addr += CHUNK_MAX_BEATS*DATA_WIDTH/8 (128), wrapping mod 2^ADDR_WIDTH, then go to REQ.
- Error is per chunk. A chunk with cpl_error still delivers all its beats, with SLVERR, and the burst continues.
- Unused high beats of a short (final) chunk are discarded.
- Chunk addresses advance by 128 regardless of araddr alignment.

## Timing
- All outputs are registered or decoded from the state register. While rst_n=0, every valid/ready output is 0 and data/ID outputs are 0.
- After reset release, arready_out=1 on the first cycle with rst_n=1.
- AR handshake at cycle N: req_valid=1 at N+1.
- req handshake at N: cpl_ready=1 at N+1.
- cpl handshake at N: first rvalid_out at N+1.
- Beats within a chunk are back-to-back when rready_in=1, with no bubbles.
- Last beat of a non-final chunk at N: req_valid at N+1.
- Last beat of the burst at N: arready_out at N+1.
- Minimum AR-to-first-R latency is 3 cycles plus the req/cpl handshake waits.
- rvalid_out, rdata_out, rresp_out, rlast_out and rid_out hold stable while rvalid_out&&!rready_in. The same holds for req_* while req_valid&&!req_ready.
- arready_out=0 outside IDLE. cpl_ready=0 outside WAIT_CPL.
- A cpl_valid outside WAIT_CPL is not consumed.
- rst_n low mid-burst: the next cycle is IDLE with all counters and the buffer cleared. No RLAST is emitted for the aborted burst.

## Test plan
- AR id=3, addr=0x1000, len=0; req_ready=1; cpl data beat0=0xAA..: one req with addr 0x1000, length 8. Then one R beat: id 3, data 0xAA.., rresp 00, rlast 1. arready returns the next cycle.
- len=3 with rready toggled 1,0,1,0: one req of length 32. Four beats in order 0..3, each held stable during stalls, rlast only on beat 3.
- len=9, addr=0x2000: three reqs at 0x2000/0x2080/0x2100 with lengths 32/32/16. Ten R beats, rlast on beat 9, and beats 2-3 of the last chunk discarded.
- len=7 with cpl_error=1 on chunk 2 only: beats 0-3 rresp 00, beats 4-7 rresp 10, rlast on beat 7.
- req_ready held 0 for 5 cycles: req_valid, req_addr and req_length stay stable, and cpl_ready stays 0 until req_ready rises.
- rst_n pulsed low during beat 2 of len=3: all outputs 0 during reset. arready=1 the cycle after release, and no further R beats for the old burst.

Source files
------------

// File: rtl/axi4_rd_responder.sv
// AXI4 read-channel responder: splits each AR burst into chunked read requests
// and replays the returned completion chunks as R beats with RID/RRESP/RLAST.
module axi4_rd_responder #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 256,
    parameter int unsigned CHUNK_MAX_BEATS = 4,
    parameter logic [15:0] REQ_BDF         = 16'h0100
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic                                  arvalid_in,
    output logic                                  arready_out,
    input  logic [ID_WIDTH-1:0]                   arid_in,
    input  logic [ADDR_WIDTH-1:0]                 araddr_in,
    input  logic [7:0]                            arlen_in,
    input  logic [2:0]                            arsize_in,
    input  logic [1:0]                            arburst_in,

    output logic                                  rvalid_out,
    input  logic                                  rready_in,
    output logic [ID_WIDTH-1:0]                   rid_out,
    output logic [DATA_WIDTH-1:0]                 rdata_out,
    output logic [1:0]                            rresp_out,
    output logic                                  rlast_out,

    output logic                                  req_valid,
    input  logic                                  req_ready,
    output logic [ADDR_WIDTH-1:0]                 req_addr,
    output logic [7:0]                            req_length,
    output logic [15:0]                           req_bdf,

    input  logic                                  cpl_valid,
    output logic                                  cpl_ready,
    input  logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] cpl_data,
    input  logic                                  cpl_error
);

    localparam int unsigned IDX_W       = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;
    localparam int unsigned CNT_W       = 9;
    localparam int unsigned CHUNK_BYTES = CHUNK_MAX_BEATS * DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_CPL = 2'd2,
        SEND     = 2'd3
    } state_t;

    state_t                                     state_q;
    state_t                                     state_d;

    logic [ID_WIDTH-1:0]                        id_q;
    logic [ADDR_WIDTH-1:0]                      cur_addr_q;
    logic [CNT_W-1:0]                           beats_left_q;
    logic [IDX_W-1:0]                           beat_idx_q;
    logic                                       err_q;
    logic [CHUNK_MAX_BEATS-1:0][DATA_WIDTH-1:0] chunk_buf_q;

    logic [CNT_W-1:0]                           chunk_beats;
    logic                                       ar_fire;
    logic                                       req_fire;
    logic                                       cpl_fire;
    logic                                       r_fire;
    logic                                       last_of_burst;
    logic                                       chunk_end;

    // AR size and burst type carry no information: beats are fixed-width INCR
    logic                                       unused_ok;
    assign unused_ok = ^{arsize_in, arburst_in};

    // Handshakes and chunk bookkeeping
    always_comb begin
        ar_fire       = arvalid_in && arready_out;
        req_fire      = req_valid && req_ready;
        cpl_fire      = cpl_valid && cpl_ready;
        r_fire        = rvalid_out && rready_in;
        last_of_burst = (beats_left_q == CNT_W'(1));
        // A chunk ends on its last slot or when the burst runs out first
        chunk_end     = last_of_burst || (beat_idx_q == IDX_W'(CHUNK_MAX_BEATS - 1));
        chunk_beats   = (beats_left_q > CNT_W'(CHUNK_MAX_BEATS)) ? CNT_W'(CHUNK_MAX_BEATS)
                                                                  : beats_left_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ar_fire) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_fire) begin
                    state_d = WAIT_CPL;
                end
            end
            WAIT_CPL: begin
                if (cpl_fire) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (r_fire && chunk_end) begin
                    state_d = last_of_burst ? IDLE : REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst context, chunk buffer and beat counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q         <= '0;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            beat_idx_q   <= '0;
            err_q        <= 1'b0;
            chunk_buf_q  <= '0;
        end else begin
            if (ar_fire) begin
                id_q         <= arid_in;
                cur_addr_q   <= araddr_in;
                beats_left_q <= CNT_W'(arlen_in) + CNT_W'(1);
            end
            if (cpl_fire) begin
                chunk_buf_q <= cpl_data;
                err_q       <= cpl_error;
                beat_idx_q  <= '0;
            end
            if (r_fire) begin
                beat_idx_q   <= beat_idx_q + IDX_W'(1);
                beats_left_q <= beats_left_q - CNT_W'(1);
                // Next chunk address steps by a full chunk whatever the start alignment
                if (chunk_end && !last_of_burst) begin
                    cur_addr_q <= cur_addr_q + ADDR_WIDTH'(CHUNK_BYTES);
                end
            end
        end
    end

    // Outputs decoded from the state and context registers; handshakes are held off during reset
    always_comb begin
        arready_out = rst_n && (state_q == IDLE);
        req_valid   = rst_n && (state_q == REQ);
        cpl_ready   = rst_n && (state_q == WAIT_CPL);
        rvalid_out  = rst_n && (state_q == SEND);
        rlast_out   = rvalid_out && last_of_burst;
        rid_out     = id_q;
        rdata_out   = chunk_buf_q[beat_idx_q];
        rresp_out   = err_q ? 2'b10 : 2'b00;
        req_addr    = cur_addr_q;
        req_length  = 8'(chunk_beats << 3);
        req_bdf     = rst_n ? REQ_BDF : 16'h0000;
    end

endmodule

// File: tb/tb_axi4_rd_responder.sv
// Bench for axi4_rd_responder: directed table, randomized bursts against a
// queue-based chunking model, and a mid-burst reset sequence.
module tb_axi4_rd_responder;

    localparam int DW  = 256;
    localparam int CMB = 4;
    localparam int CW  = DW * CMB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            arvalid_in;
    logic            arready_out;
    logic [3:0]      arid_in;
    logic [31:0]     araddr_in;
    logic [7:0]      arlen_in;
    logic [2:0]      arsize_in;
    logic [1:0]      arburst_in;
    logic            rvalid_out;
    logic            rready_in;
    logic [3:0]      rid_out;
    logic [DW-1:0]   rdata_out;
    logic [1:0]      rresp_out;
    logic            rlast_out;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [7:0]      req_length;
    logic [15:0]     req_bdf;
    logic            cpl_valid;
    logic            cpl_ready;
    logic [CW-1:0]   cpl_data;
    logic            cpl_error;

    always #5 clk = ~clk;

    axi4_rd_responder dut (
        .clk(clk), .rst_n(rst_n),
        .arvalid_in(arvalid_in), .arready_out(arready_out), .arid_in(arid_in),
        .araddr_in(araddr_in), .arlen_in(arlen_in), .arsize_in(arsize_in),
        .arburst_in(arburst_in),
        .rvalid_out(rvalid_out), .rready_in(rready_in), .rid_out(rid_out),
        .rdata_out(rdata_out), .rresp_out(rresp_out), .rlast_out(rlast_out),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_length(req_length), .req_bdf(req_bdf),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_data(cpl_data),
        .cpl_error(cpl_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [63:0] err_mask;
        int          rr_mode;
        int          req_hold;
        bit          rnd;
        logic [7:0]  fill;
        int          exp_reqs;
        int          exp_beats;
        logic [31:0] exp_last_addr;
        logic [7:0]  exp_last_len;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        bit            last;
        bit            ce;
    } beat_t;

    function automatic void chk(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [CW-1:0] rand_chunk(input logic [7:0] fill);
        logic [CW-1:0] p;
        for (int w = 0; w < CW / 32; w++) begin
            p[w*32 +: 32] = (fill != 8'd0) ? {4{fill}} : $urandom;
        end
        return p;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_arready"},  DW'(arready_out), DW'(0));
        chk({tag, "_rvalid"},   DW'(rvalid_out),  DW'(0));
        chk({tag, "_req_valid"},DW'(req_valid),   DW'(0));
        chk({tag, "_cpl_ready"},DW'(cpl_ready),   DW'(0));
        chk({tag, "_rlast"},    DW'(rlast_out),   DW'(0));
        chk({tag, "_rdata"},    rdata_out,        DW'(0));
        chk({tag, "_rid"},      DW'(rid_out),     DW'(0));
        chk({tag, "_rresp"},    DW'(rresp_out),   DW'(0));
        chk({tag, "_req_addr"}, DW'(req_addr),    DW'(0));
        chk({tag, "_req_len"},  DW'(req_length),  DW'(0));
        chk({tag, "_req_bdf"},  DW'(req_bdf),     DW'(0));
    endtask

    task automatic drive_idle();
        arvalid_in = 1'b0;
        rready_in  = 1'b0;
        req_ready  = 1'b0;
        cpl_valid  = 1'b0;
        cpl_error  = 1'b0;
    endtask

    // One AR burst end to end; expected requests and beats come from plain chunk arithmetic
    task automatic run_burst(input vec_t v, input int abort_beat, output int nreq,
                             output int nbeat, output logic [31:0] last_addr,
                             output logic [7:0] last_len);
        req_t          rq[$];
        beat_t         br[$];
        logic [CW-1:0] pay[$];
        bit            errq[$];
        logic [CW-1:0] p;
        beat_t         b;
        req_t          r;
        int            rem, c, n, cyc, hold;
        bit            ar_pend, want_req, want_cpl, sending, done, tog;
        bit            ar_f, req_f, cpl_f, r_f;

        rem = int'(v.len) + 1;
        c   = 0;
        while (rem > 0) begin
            n      = (rem > CMB) ? CMB : rem;
            r.addr = v.addr + 32'(c * 128);
            r.len  = 8'(n * 8);
            rq.push_back(r);
            p = rand_chunk(v.fill);
            pay.push_back(p);
            errq.push_back(v.err_mask[c]);
            for (int k = 0; k < n; k++) begin
                b.data = p[k*DW +: DW];
                b.resp = v.err_mask[c] ? 2'b10 : 2'b00;
                b.last = (rem - k == 1);
                b.ce   = (k == n - 1);
                br.push_back(b);
            end
            rem -= n;
            c++;
        end

        nreq = 0; nbeat = 0; last_addr = '0; last_len = '0;
        ar_pend = 1; want_req = 0; want_cpl = 0; sending = 0; done = 0;
        cyc = 0; hold = 0; tog = 1;
        arid_in = v.id; araddr_in = v.addr; arlen_in = v.len;
        arsize_in = 3'd5; arburst_in = 2'b01;

        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            chk("arready", DW'(arready_out), DW'(!(want_req || want_cpl || sending)));
            chk("req_valid", DW'(req_valid), DW'(want_req));
            if (want_req && req_valid && rq.size() > 0) begin
                chk("req_addr", DW'(req_addr),   DW'(rq[0].addr));
                chk("req_len",  DW'(req_length), DW'(rq[0].len));
                chk("req_bdf",  DW'(req_bdf),    DW'(16'h0100));
            end
            chk("cpl_ready", DW'(cpl_ready), DW'(want_cpl));
            chk("rvalid", DW'(rvalid_out), DW'(sending));
            if (sending && rvalid_out && br.size() > 0) begin
                chk("rid",   DW'(rid_out),   DW'(v.id));
                chk("rdata", rdata_out,      br[0].data);
                chk("rresp", DW'(rresp_out), DW'(br[0].resp));
                chk("rlast", DW'(rlast_out), DW'(br[0].last));
            end
            if (abort_beat >= 0 && sending && rvalid_out && nbeat == abort_beat) begin
                break;
            end

            arvalid_in = ar_pend;
            ar_f = ar_pend && arready_out;

            req_ready = v.rnd ? 1'($urandom % 2) : (hold >= v.req_hold);
            req_f = req_valid && req_ready;
            if (want_req && !req_f) hold++;
            if (req_f) hold = 0;

            if (want_cpl && pay.size() > 0) begin
                cpl_valid = v.rnd ? 1'($urandom % 2) : 1'b1;
                cpl_data  = pay[0];
                cpl_error = errq[0];
            end else begin
                cpl_valid = v.rnd ? 1'($urandom % 4 == 0) : 1'b0;
                cpl_data  = rand_chunk(8'd0);
                cpl_error = 1'($urandom % 2);
            end
            cpl_f = cpl_valid && cpl_ready;

            case (v.rr_mode)
                0:       rready_in = 1'b1;
                1:       rready_in = tog;
                default: rready_in = 1'($urandom % 2);
            endcase
            if (sending) tog = !tog;
            r_f = rvalid_out && rready_in;

            if (ar_f) begin
                ar_pend  = 0;
                want_req = 1;
            end
            if (req_f) begin
                want_req  = 0;
                want_cpl  = 1;
                nreq++;
                last_addr = req_addr;
                last_len  = req_length;
                if (rq.size() > 0) void'(rq.pop_front());
            end
            if (cpl_f) begin
                want_cpl = 0;
                sending  = 1;
                if (pay.size() > 0) void'(pay.pop_front());
                if (errq.size() > 0) void'(errq.pop_front());
            end
            if (r_f) begin
                nbeat++;
                if (br.size() > 0) begin
                    b = br.pop_front();
                    if (b.ce) begin
                        sending = 0;
                        if (b.last) done = 1;
                        else want_req = 1;
                    end
                end else begin
                    done = 1;
                end
            end
        end

        if (abort_beat < 0) begin
            chk("burst_done", DW'(done), DW'(1));
            @(negedge clk);
            chk("arready_after_last", DW'(arready_out), DW'(1));
            chk("rvalid_after_last",  DW'(rvalid_out),  DW'(0));
            chk("req_valid_after",    DW'(req_valid),   DW'(0));
            drive_idle();
        end
    endtask

    vec_t        tbl[7];
    vec_t        v;
    int          nr, nb;
    logic [31:0] la;
    logic [7:0]  ll;

    initial begin
        rst_n = 1'b0;
        drive_idle();
        arid_in = '0; araddr_in = '0; arlen_in = '0; arsize_in = '0; arburst_in = '0;
        cpl_data = '0;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_after_reset", DW'(arready_out), DW'(1));
        chk("rvalid_after_reset",  DW'(rvalid_out),  DW'(0));

        //          id     addr           len     err_mask                rr hold rnd fill   reqs beats last_addr      last_len
        tbl[0] = '{4'd3,  32'h0000_1000, 8'd0,   64'd0,                  0, 0,   0,  8'hAA, 1,   1,    32'h0000_1000, 8'd8};
        tbl[1] = '{4'd5,  32'h0000_3000, 8'd3,   64'd0,                  1, 0,   0,  8'h00, 1,   4,    32'h0000_3000, 8'd32};
        tbl[2] = '{4'd9,  32'h0000_2000, 8'd9,   64'd0,                  0, 0,   0,  8'h00, 3,   10,   32'h0000_2100, 8'd16};
        tbl[3] = '{4'd1,  32'h0000_4000, 8'd7,   64'h2,                  0, 0,   0,  8'h00, 2,   8,    32'h0000_4080, 8'd32};
        tbl[4] = '{4'd6,  32'h0000_5000, 8'd5,   64'd0,                  0, 5,   0,  8'h00, 2,   6,    32'h0000_5080, 8'd16};
        tbl[5] = '{4'd15, 32'hFFFF_FFC0, 8'd8,   64'd0,                  2, 0,   1,  8'h00, 3,   9,    32'h0000_00C0, 8'd8};
        tbl[6] = '{4'd0,  32'h0000_0010, 8'd255, 64'hF0F0_F0F0_F0F0_F0F0, 2, 0,   1,  8'h00, 64,  256,  32'h0000_1F90, 8'd32};

        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i], -1, nr, nb, la, ll);
            chk($sformatf("vec%0d_reqs", i),      DW'(nr), DW'(tbl[i].exp_reqs));
            chk($sformatf("vec%0d_beats", i),     DW'(nb), DW'(tbl[i].exp_beats));
            chk($sformatf("vec%0d_last_addr", i), DW'(la), DW'(tbl[i].exp_last_addr));
            chk($sformatf("vec%0d_last_len", i),  DW'(ll), DW'(tbl[i].exp_last_len));
        end

        for (int i = 0; i < 25; i++) begin
            v.id       = 4'($urandom);
            v.addr     = $urandom;
            v.len      = (i % 8 == 7) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 20));
            v.err_mask = {$urandom, $urandom};
            v.rr_mode  = 2;
            v.req_hold = 0;
            v.rnd      = 1;
            v.fill     = 8'd0;
            run_burst(v, -1, nr, nb, la, ll);
            chk($sformatf("rnd%0d_beats", i), DW'(nb), DW'(int'(v.len) + 1));
            chk($sformatf("rnd%0d_reqs", i),  DW'(nr), DW'((int'(v.len) + CMB) / CMB));
        end

        // Reset while beat 2 of a four-beat burst is on the bus
        v = '{4'd7, 32'h0000_6000, 8'd3, 64'd0, 0, 0, 0, 8'h00, 1, 4, 32'h0000_6000, 8'd32};
        run_burst(v, 2, nr, nb, la, ll);
        chk("abort_beat_reached", DW'(nb), DW'(2));
        rst_n      = 1'b0;
        arvalid_in = 1'b0;
        rready_in  = 1'b1;
        cpl_valid  = 1'b0;
        req_ready  = 1'b1;
        @(negedge clk);
        chk_zero("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("arready_after_abort", DW'(arready_out), DW'(1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_rvalid", DW'(rvalid_out), DW'(0));
            chk("no_stale_rlast",  DW'(rlast_out),  DW'(0));
        end
        drive_idle();

        run_burst(tbl[2], -1, nr, nb, la, ll);
        chk("recover_beats", DW'(nb), DW'(tbl[2].exp_beats));
        chk("recover_reqs",  DW'(nr), DW'(tbl[2].exp_reqs));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
